// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
//   Shared types and constants for the register-file write-port arbiter.
//   - REG_ADDR_W / DATA_W : register address and data widths
//   - PC_REG              : register index that aux producers may not write
//   - arb_state_e         : arbiter state (idle / pending / forced stall)
//   - rf_entry_t          : one queued aux write {dest, data}
//   - onehot_dest()       : decode a register index into a 16-bit mask
// ---------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int              REG_ADDR_W = 4;
    localparam int              DATA_W     = 32;
    localparam int              NUM_REGS   = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PEND,
        ARB_FORCE
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } rf_entry_t;

    function automatic logic [NUM_REGS-1:0] onehot_dest(input logic [REG_ADDR_W-1:0] d);
        return NUM_REGS'(1) << d;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// ---------------------------------------------------------------------------
// rf_arb_fifo
//   In-order queue of pending aux register writes.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     push, push_entry    enqueue one entry (caller guarantees !full)
//     pop                 dequeue the head (caller guarantees !empty)
//     full, empty, count  occupancy
//     head                oldest entry
//     entry_valid/dest    per-slot occupancy and destination, for busy_mask
//   Pointers carry one extra bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  rf_entry_t                           push_entry,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(DEPTH):0]              count,
    output rf_entry_t                           head,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_dest
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rf_entry_t   mem [DEPTH];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Distance of a slot from the read pointer, modulo DEPTH.
    function automatic logic [AW-1:0] slot_offset(input int slot, input logic [AW-1:0] rd);
        return AW'(slot) - rd;
    endfunction

    // A slot is live when it lies fewer than `count` places past the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, slot_offset(i, rd_ptr[AW-1:0])} < count);
            entry_dest[i]  = mem[i].dest;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the register file's single write port between the WB stage
//   (priority) and an auxiliary multi-cycle producer whose results queue in
//   a small FIFO. A starvation timer forces a one-cycle WB stall so queued
//   aux writes always retire.
//   Ports:
//     clk, rst                         clock, asynchronous active-low reset
//     wb_en, wb_dest, wb_data          WB stage write request
//     stall_wb                         WB frozen this cycle, its write not done
//     aux_valid/ready/dest/data        aux producer handshake
//     aux_err                          pulse: accepted aux write to r15 dropped
//     rf_we, rf_dest, rf_data          register-file write port
//     busy_mask                        registers with a queued aux write
//   Build option: RFA_BYPASS_EN - an aux write arriving while the queue is
//   empty and WB is idle goes straight to the register file the same cycle.
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall_wb,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    input  logic [REG_ADDR_W-1:0] aux_dest,
    input  logic [DATA_W-1:0]     aux_data,
    output logic                  aux_err,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0]     rf_data,
    output logic [NUM_REGS-1:0]   busy_mask
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    arb_state_e                       state;
    logic [CNT_W-1:0]                 wait_cnt;
    logic [CNT_W-1:0]                 wait_inc;

    logic                             full;
    logic                             empty;
    logic [OCC_W-1:0]                 count;
    rf_entry_t                        head;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_dest;

    logic accept;
    logic aux_is_pc;
    logic push;
    logic pop;
    logic bypass;
    logic drains;

    assign aux_ready = rst & ~full;
    assign accept    = aux_valid & aux_ready;
    assign aux_is_pc = (aux_dest == PC_REG);
    assign push      = accept & ~aux_is_pc & ~bypass;

    // The queue empties at this edge: last entry leaves, nothing replaces it.
    assign drains    = pop && (count == OCC_W'(1)) && !push;

    assign wait_inc  = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  ('{dest: aux_dest, data: aux_data}),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .head        (head),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    // Write-port grant. Gated by rst so nothing is written while in reset.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_dest  = '0;
        rf_data  = '0;
        stall_wb = 1'b0;
        pop      = 1'b0;
        bypass   = 1'b0;
        if (rst) begin
            if (state == ARB_FORCE) begin
                rf_we    = 1'b1;
                rf_dest  = head.dest;
                rf_data  = head.data;
                stall_wb = 1'b1;
                pop      = 1'b1;
            end else if (wb_en) begin
                rf_we    = 1'b1;
                rf_dest  = wb_dest;
                rf_data  = wb_data;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_dest  = head.dest;
                rf_data  = head.data;
                pop      = 1'b1;
            end
`ifdef RFA_BYPASS_EN
            else if (state == ARB_IDLE && aux_valid && !aux_is_pc) begin
                rf_we    = 1'b1;
                rf_dest  = aux_dest;
                rf_data  = aux_data;
                bypass   = 1'b1;
            end
`endif
        end
    end

    // Starvation FSM: wait_cnt counts cycles the current head was passed over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
            aux_err  <= 1'b0;
        end else begin
            aux_err <= accept & aux_is_pc;
            case (state)
                ARB_IDLE: begin
                    wait_cnt <= '0;
                    if (push) state <= ARB_PEND;
                end
                ARB_PEND: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        state    <= drains ? ARB_IDLE : ARB_PEND;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIMIT) state <= ARB_FORCE;
                    end
                end
                ARB_FORCE: begin
                    wait_cnt <= '0;
                    state    <= drains ? ARB_IDLE : ARB_PEND;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) busy_mask = busy_mask | onehot_dest(entry_dest[i]);
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between the pipeline WB stage and one auxiliary multi-cycle producer (multiplier or load-multiple unit).
- WB has priority. Aux results queue in a small FIFO and drain into idle WB slots.
- A starvation timer forces a one-cycle WB stall so queued aux writes always retire.
- Exports a busy mask so the hazard unit can stall reads of registers with queued aux writes.

Parameters:
- DEPTH, 2, aux FIFO entries (power of 2, ≥2).
- MAX_WAIT, 4, cycles a non-empty FIFO head may wait before forcing a WB stall (≥1).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- wb_en  in  1  WB stage write request.
- wb_dest  in  4  WB destination register.
- wb_data  in  32  WB result.
- stall_wb  out  1  freeze WB and earlier stages this cycle; WB write not performed.
- aux_valid  in  1  aux result offered.
- aux_ready  out  1  FIFO can accept.
- aux_dest  in  4  aux destination register.
- aux_data  in  32  aux result.
- aux_err  out  1  one-cycle pulse: accepted aux write to r15 was dropped.
- rf_we  out  1  register-file write enable.
- rf_dest  out  4  register-file write address.
- rf_data  out  32  register-file write data.
- busy_mask  out  16  bit n set iff a FIFO entry targets rn.

Behaviour:
- Reset (rst low, async):
  - FIFO empty, wait counter 0, state IDLE, aux_err 0.
  - While rst is low: aux_ready=0, rf_we=0, stall_wb=0, busy_mask=0.
- aux_ready = rst & ~full. Push occurs on posedge when aux_valid & aux_ready; no push-through-full.
- aux_dest==15 on an accepted beat: entry not stored; aux_err=1 for the following cycle.
- Grant, combinational from registered state and current inputs:
  - FORCE state: write FIFO head; stall_wb=1; wb_en ignored this cycle. The pipeline re-presents the same WB write next cycle.
  - Else if wb_en: write WB (rf_dest=wb_dest, rf_data=wb_data).
  - Else if FIFO non-empty: write head; pop at posedge.
  - Else rf_we=0; rf_dest and rf_data hold 0.
- State machine:
  - IDLE (FIFO empty) -> PEND on push.
  - PEND: counter increments each cycle head not popped, saturating at MAX_WAIT; counter clears on pop.
    - Counter reaches MAX_WAIT -> FORCE.
    - FIFO becomes empty -> IDLE.
  - FORCE lasts exactly one cycle (head popped), counter cleared. Next state: PEND if entries remain, else IDLE.
- Aux write latency:
  - Minimum 1 cycle (push, then write next cycle when WB idle).
  - Worst case with WB saturated: (entries ahead + 1) × (MAX_WAIT + 1) cycles.
- Simultaneous push and pop: both occur; occupancy unchanged.
  - Pop of the last entry with a same-cycle push stays in PEND with counter 0.
- Ordering:
  - FIFO is strictly in order.
  - No squash or reordering between WB and aux for the same dest. The hazard unit uses busy_mask to prevent WAW/RAW.
- busy_mask is registered-state derived: OR of one-hot(dest) over valid entries. It updates the cycle after push or pop.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset mid-operation: queued entries are discarded with no write; stall_wb drops immediately.

Optional Feature:
- RFA_BYPASS_EN defined: when FIFO empty, state IDLE, wb_en=0 and aux_valid=1 with aux_dest≠15:
  - Aux data is written combinationally the same cycle (rf_we=1) and not enqueued.
  - busy_mask is unaffected.
- Undefined: every aux write passes through the FIFO (minimum latency 1 cycle).

Decomposition:
- Package rf_arb_pkg:
  - REG_ADDR_W=4, DATA_W=32, PC_REG=4'd15.
  - State enum {ARB_IDLE, ARB_PEND, ARB_FORCE}.
  - Entry struct {dest, data}.
- Sub-module rf_arb_fifo:
  - Parameterised DEPTH; push, pop, full, empty, head entry, and per-entry valid/dest vector for busy_mask.

Test Plan:
- Reset release, idle: rf_we=0, aux_ready=1, busy_mask=0.
- Aux write r3=0xDEADBEEF with wb_en=0 pushed at cycle t -> cycle t+1: rf_we=1, rf_dest=3, rf_data=0xDEADBEEF; busy_mask[3] set for t+1 only.
- wb_en held 1 (r1=0x11) and one aux entry r5=0x55 queued, MAX_WAIT=4 -> four WB writes, then one cycle stall_wb=1 writing r5=0x55, then WB r1 resumes.
- Push 2 entries (r2, r4) while WB busy -> aux_ready=0, busy_mask=0x0014; third aux_valid held until first pop.
- Aux to r15 -> no FIFO entry, aux_err pulses once, busy_mask unchanged.
- rst low while FORCE with 2 entries queued -> stall_wb=0 and rf_we=0 immediately; after release FIFO empty and no stale writes.
